// File: rtl/vector_regfile_sb.sv
// vector_regfile_sb
//   Vector register file with an integrated write scoreboard. It holds NREGS
//   registers, each LANES x ELEM_W bits wide. Decode/issue reads operands and
//   marks destinations pending. Writeback performs lane-masked writes and
//   clears the pending flag on the last beat.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   rs1..rs3          read addresses (out-of-range reads return 0, not busy)
//   rd1..rd3          read data, lane i at [i*ELEM_W +: ELEM_W]
//   rs_busy           pending flag per read port (bit k-1 for rsk)
//   wr_en, wr_addr    write strobe and destination register
//   wr_data, wr_mask  write data and per-lane write enable
//   wr_last           last beat: clears pending flag of wr_addr
//   iss_en, iss_addr  mark iss_addr pending
//   iss_busy          pending flag of iss_addr (WAW check)
//   flush             clear every pending flag
//   pend              registered pending vector
module vector_regfile_sb #(
  parameter int LANES  = 8,
  parameter int ELEM_W = 24,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 4,
  parameter int BYPASS = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         rs1,
  input  logic [ADDR_W-1:0]         rs2,
  input  logic [ADDR_W-1:0]         rs3,
  output logic [LANES*ELEM_W-1:0]   rd1,
  output logic [LANES*ELEM_W-1:0]   rd2,
  output logic [LANES*ELEM_W-1:0]   rd3,
  output logic [2:0]                rs_busy,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [LANES*ELEM_W-1:0]   wr_data,
  input  logic [LANES-1:0]          wr_mask,
  input  logic                      wr_last,
  input  logic                      iss_en,
  input  logic [ADDR_W-1:0]         iss_addr,
  output logic                      iss_busy,
  input  logic                      flush,
  output logic [NREGS-1:0]          pend
);

  localparam int N     = LANES * ELEM_W;
  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [N-1:0]      regs [NREGS];
  logic [NREGS-1:0]  pend_q;
  logic [NREGS-1:0]  pend_nxt;
  logic [ADDR_W-1:0] rs_a [3];
  logic [N-1:0]      rd_a [3];
  logic              wr_ok;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (32'(a) < NREGS);
  endfunction

  assign rs_a[0] = rs1;
  assign rs_a[1] = rs2;
  assign rs_a[2] = rs3;
  assign rd1     = rd_a[0];
  assign rd2     = rd_a[1];
  assign rd3     = rd_a[2];
  assign pend    = pend_q;
  assign wr_ok   = wr_en && in_range(wr_addr);

  // Read ports: each port reads the stored value. When bypass is enabled, a
  // same-cycle write to the same register overrides the lanes it enables.
  // The busy flags come only from the registered pend vector, so a clear in
  // the current cycle does not release the stall until the next cycle.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      rd_a[k]    = '0;
      rs_busy[k] = 1'b0;
      if (in_range(rs_a[k])) begin
        rd_a[k]    = regs[rs_a[k][IDX_W-1:0]];
        rs_busy[k] = pend_q[rs_a[k][IDX_W-1:0]];
        if ((BYPASS != 0) && wr_ok && (wr_addr == rs_a[k])) begin
          for (int i = 0; i < LANES; i++) begin
            if (wr_mask[i]) rd_a[k][i*ELEM_W +: ELEM_W] = wr_data[i*ELEM_W +: ELEM_W];
          end
        end
      end
    end
  end

  // WAW check for the instruction being issued; out-of-range never stalls.
  always_comb begin
    iss_busy = 1'b0;
    if (in_range(iss_addr)) iss_busy = pend_q[iss_addr[IDX_W-1:0]];
  end

  // Register storage: only the lanes enabled by wr_mask are updated, and an
  // out-of-range address leaves every register untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_mask[i]) regs[wr_addr[IDX_W-1:0]][i*ELEM_W +: ELEM_W] <= wr_data[i*ELEM_W +: ELEM_W];
      end
    end
  end

  // Scoreboard next state. Flush beats everything. An issue to a register
  // beats a last-beat clear of that same register, because the new producer
  // is still outstanding. The address is compared at full width against the
  // loop index, so out-of-range addresses never match any register.
  always_comb begin
    pend_nxt = pend_q;
    if (flush) begin
      pend_nxt = '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (iss_en && (32'(iss_addr) == r))
          pend_nxt[r] = 1'b1;
        else if (wr_en && wr_last && (32'(wr_addr) == r))
          pend_nxt[r] = 1'b0;
      end
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_nxt;
  end

endmodule
